// File: rtl/vga_pic_proc.sv
// Picture-window renderer: places an H_PIC x V_PIC ROM image at a run-time window
// position and renders it in colour, grey, binary or blanked mode with optional inversion.
module vga_pic_proc #(
    parameter int unsigned HOR_SCREEN  = 800,
    parameter int unsigned VERT_SCREEN = 480,
    parameter int unsigned H_PIC       = 160,
    parameter int unsigned V_PIC       = 160,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned ROM_LAT     = 1,
    parameter logic [23:0] BG_COLOR    = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [9:0]        win_x,
    input  logic [9:0]        win_y,
    input  logic [1:0]        mode,
    input  logic [7:0]        thresh,
    input  logic              invert,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rden,
    input  logic [23:0]       rom_q,
    output logic [23:0]       color_data_out,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        MODE_COLOR = 2'd0,
        MODE_GREY  = 2'd1,
        MODE_BIN   = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIC * V_PIC - 1);

    // Frame-level shadow registers
    logic [9:0]        wx, wy;
    mode_t             mode_r;
    logic [7:0]        thresh_r;
    logic              invert_r;
    logic [ADDR_W-1:0] cnt;

    // Effective per-pixel values: on the boundary cycle itself the new latch applies
    logic              fb, win_ok, in_win, active;
    logic [9:0]        cur_wx, cur_wy;
    mode_t             cur_mode;
    logic [7:0]        cur_thresh;
    logic              cur_invert;
    logic [ADDR_W-1:0] cnt_base;

    always_comb begin
        fb         = (pix_x == '0) && (pix_y == '0);
        win_ok     = ({1'b0, win_x} + 11'(H_PIC) <= 11'(HOR_SCREEN)) &&
                     ({1'b0, win_y} + 11'(V_PIC) <= 11'(VERT_SCREEN));
        cur_wx     = (fb && win_ok) ? win_x : wx;
        cur_wy     = (fb && win_ok) ? win_y : wy;
        cur_mode   = fb ? mode_t'(mode) : mode_r;
        cur_thresh = fb ? thresh : thresh_r;
        cur_invert = fb ? invert : invert_r;
        cnt_base   = fb ? '0 : cnt;
        in_win     = ({1'b0, pix_x} >= {1'b0, cur_wx}) &&
                     ({1'b0, pix_x} <  {1'b0, cur_wx} + 11'(H_PIC)) &&
                     ({1'b0, pix_y} >= {1'b0, cur_wy}) &&
                     ({1'b0, pix_y} <  {1'b0, cur_wy} + 11'(V_PIC));
        active     = in_win && (cur_mode != MODE_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wx       <= '0;
            wy       <= '0;
            mode_r   <= MODE_COLOR;
            thresh_r <= '0;
            invert_r <= 1'b0;
        end else if (fb) begin
            mode_r   <= mode_t'(mode);
            thresh_r <= thresh;
            invert_r <= invert;
            if (win_ok) begin
                wx <= win_x;
                wy <= win_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            rom_addr   <= '0;
            rom_rden   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rom_rden   <= active;
            frame_done <= active && (cnt_base == LAST_ADDR);
            if (active) begin
                rom_addr <= cnt_base;
                cnt      <= cnt_base + 1'b1;
            end else begin
                cnt      <= cnt_base;
            end
        end
    end

    // Per-pixel controls ride alongside the ROM read; index ROM_LAT lines up with rom_q
    logic  p_flag   [0:ROM_LAT];
    mode_t p_mode   [0:ROM_LAT];
    logic [7:0] p_thresh [0:ROM_LAT];
    logic  p_inv    [0:ROM_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                p_flag[i]   <= 1'b0;
                p_mode[i]   <= MODE_COLOR;
                p_thresh[i] <= '0;
                p_inv[i]    <= 1'b0;
            end
        end else begin
            p_flag[0]   <= active;
            p_mode[0]   <= cur_mode;
            p_thresh[0] <= cur_thresh;
            p_inv[0]    <= cur_invert;
            for (int unsigned i = 1; i <= ROM_LAT; i++) begin
                p_flag[i]   <= p_flag[i-1];
                p_mode[i]   <= p_mode[i-1];
                p_thresh[i] <= p_thresh[i-1];
                p_inv[i]    <= p_inv[i-1];
            end
        end
    end

    logic [15:0] gray_sum;
    logic [7:0]  gray;

    always_comb begin
        gray_sum = 16'd77  * {8'b0, rom_q[23:16]} +
                   16'd150 * {8'b0, rom_q[15:8]}  +
                   16'd29  * {8'b0, rom_q[7:0]};
        gray     = gray_sum[15:8];
    end

    logic [23:0] q_r;
    logic [7:0]  gray_r;
    logic        bin_r, s2_flag, s2_inv;
    mode_t       s2_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= '0;
            gray_r  <= '0;
            bin_r   <= 1'b0;
            s2_flag <= 1'b0;
            s2_inv  <= 1'b0;
            s2_mode <= MODE_COLOR;
        end else begin
            q_r     <= rom_q;
            gray_r  <= gray;
            bin_r   <= (gray >= p_thresh[ROM_LAT]);
            s2_flag <= p_flag[ROM_LAT];
            s2_inv  <= p_inv[ROM_LAT];
            s2_mode <= p_mode[ROM_LAT];
        end
    end

    logic [23:0] pic;

    always_comb begin
        pic = q_r;
        case (s2_mode)
            MODE_COLOR: pic = q_r;
            MODE_GREY:  pic = {3{gray_r}};
            MODE_BIN:   pic = bin_r ? '1 : '0;
            default:    pic = q_r;
        endcase
        pic = pic ^ {24{s2_inv}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) color_data_out <= BG_COLOR;
        else     color_data_out <= s2_flag ? pic : BG_COLOR;
    end

endmodule

// File: tb/tb_vga_pic_proc.sv
// Directed bench for vga_pic_proc: window placement, address sequencing, render modes,
// frame-boundary shadowing and asynchronous reset.
module tb_vga_pic_proc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  pix_x = 10'd0, pix_y = 10'd479;
    logic [9:0]  win_x = 10'd0, win_y = 10'd0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  thresh = 8'd0;
    logic        invert = 1'b0;
    logic [15:0] rom_addr;
    logic        rom_rden;
    logic [23:0] rom_q = '0;
    logic [23:0] color_data_out;
    logic        frame_done;

    logic        rom_const_en = 1'b0;
    logic [23:0] rom_const = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ROM model, one cycle latency
    always @(posedge clk) rom_q <= rom_const_en ? rom_const : {8'h00, rom_addr};

    vga_pic_proc #(
        .HOR_SCREEN(800), .VERT_SCREEN(480), .H_PIC(160), .V_PIC(160),
        .ADDR_W(16), .ROM_LAT(1), .BG_COLOR(24'hFFFFFF)
    ) dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
        .win_x(win_x), .win_y(win_y), .mode(mode), .thresh(thresh), .invert(invert),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
        .color_data_out(color_data_out), .frame_done(frame_done)
    );

    task automatic frame_start();
        @(negedge clk);
        pix_x = 10'd0;
        pix_y = 10'd0;
    endtask

    // Drive one pixel, then park on an out-of-window pixel; capture the ROM-side
    // outputs one cycle later and the pixel output four cycles later.
    task automatic probe(input int x, input int y, output logic rden, output logic [15:0] addr,
                         output logic fd, output logic [23:0] col);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(negedge clk);
        rden = rom_rden;
        addr = rom_addr;
        fd   = frame_done;
        pix_x = 10'd0;
        pix_y = 10'd479;
        repeat (3) @(negedge clk);
        col = color_data_out;
    endtask

    // Stream every window pixel except the first and the last
    task automatic scan_window(input int x0, input int y0);
        for (int y = 0; y < 160; y++) begin
            for (int x = 0; x < 160; x++) begin
                if (!((x == 0 && y == 0) || (x == 159 && y == 159))) begin
                    @(negedge clk);
                    pix_x = 10'(x0 + x);
                    pix_y = 10'(y0 + y);
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (color_data_out !== 24'hFFFFFF) begin failures++; $display("FAIL reset_color got=%h exp=ffffff", color_data_out); end
        checks++; if (rom_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", rom_rden); end
        checks++; if (rom_addr !== 16'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_colour();
        logic rd, fd; logic [15:0] a; logic [23:0] c;
        rom_const_en = 1'b0;
        win_x = 10'd500; win_y = 10'd200; mode = 2'd0; invert = 1'b0;
        frame_start();
        probe(500, 200, rd, a, fd, c);
        checks++; if (rd !== 1'b1) begin failures++; $display("FAIL col_first_rden got=%b exp=1", rd); end
        checks++; if (a !== 16'd0) begin failures++; $display("FAIL col_first_addr got=%0d exp=0", a); end
        checks++; if (fd !== 1'b0) begin failures++; $display("FAIL col_first_fd got=%b exp=0", fd); end
        checks++; if (c !== 24'h000000) begin failures++; $display("FAIL col_first_pix got=%h exp=000000", c); end
        probe(499, 200, rd, a, fd, c);
        checks++; if (rd !== 1'b0) begin failures++; $display("FAIL col_left_rden got=%b exp=0", rd); end
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL col_left_bg got=%h exp=ffffff", c); end
        probe(660, 200, rd, a, fd, c);
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL col_right_bg got=%h exp=ffffff", c); end
        scan_window(500, 200);
        probe(659, 359, rd, a, fd, c);
        checks++; if (rd !== 1'b1) begin failures++; $display("FAIL col_last_rden got=%b exp=1", rd); end
        checks++; if (a !== 16'd25599) begin failures++; $display("FAIL col_last_addr got=%0d exp=25599", a); end
        checks++; if (fd !== 1'b1) begin failures++; $display("FAIL col_last_fd got=%b exp=1", fd); end
        checks++; if (c !== 24'h0063FF) begin failures++; $display("FAIL col_last_pix got=%h exp=0063ff", c); end
    endtask

    task automatic test_grey();
        logic rd, fd; logic [15:0] a; logic [23:0] c;
        rom_const_en = 1'b1; rom_const = 24'hFF0000; mode = 2'd1;
        frame_start();
        probe(500, 200, rd, a, fd, c);
        checks++; if (c !== 24'h4C4C4C) begin failures++; $display("FAIL grey_red got=%h exp=4c4c4c", c); end
        rom_const = 24'hFFFFFF;
        probe(501, 200, rd, a, fd, c);
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL grey_white got=%h exp=ffffff", c); end
    endtask

    task automatic test_binary();
        logic rd, fd; logic [15:0] a; logic [23:0] c;
        mode = 2'd2; thresh = 8'h80; invert = 1'b0;
        frame_start();
        rom_const = 24'h808080;
        probe(500, 200, rd, a, fd, c);
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL bin_at_thresh got=%h exp=ffffff", c); end
        rom_const = 24'h7F7F7F;
        probe(501, 200, rd, a, fd, c);
        checks++; if (c !== 24'h000000) begin failures++; $display("FAIL bin_below got=%h exp=000000", c); end
        invert = 1'b1;
        frame_start();
        rom_const = 24'h808080;
        probe(500, 200, rd, a, fd, c);
        checks++; if (c !== 24'h000000) begin failures++; $display("FAIL bin_inv_at got=%h exp=000000", c); end
        rom_const = 24'h7F7F7F;
        probe(501, 200, rd, a, fd, c);
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL bin_inv_below got=%h exp=ffffff", c); end
        probe(100, 100, rd, a, fd, c);
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL bin_inv_bg got=%h exp=ffffff", c); end
    endtask

    task automatic test_mode_change();
        logic rd, fd; logic [15:0] a; logic [23:0] c;
        rom_const = 24'hFF0000; mode = 2'd0; invert = 1'b0;
        frame_start();
        probe(500, 200, rd, a, fd, c);
        checks++; if (c !== 24'hFF0000) begin failures++; $display("FAIL mc_colour got=%h exp=ff0000", c); end
        mode = 2'd1;
        probe(500, 300, rd, a, fd, c);
        checks++; if (c !== 24'hFF0000) begin failures++; $display("FAIL mc_midframe got=%h exp=ff0000", c); end
        frame_start();
        probe(500, 200, rd, a, fd, c);
        checks++; if (c !== 24'h4C4C4C) begin failures++; $display("FAIL mc_nextframe got=%h exp=4c4c4c", c); end
        mode = 2'd3; invert = 1'b1;
        frame_start();
        probe(500, 200, rd, a, fd, c);
        checks++; if (rd !== 1'b0) begin failures++; $display("FAIL off_rden got=%b exp=0", rd); end
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL off_pix got=%h exp=ffffff", c); end
        probe(659, 359, rd, a, fd, c);
        checks++; if (rd !== 1'b0) begin failures++; $display("FAIL off_last_rden got=%b exp=0", rd); end
        checks++; if (fd !== 1'b0) begin failures++; $display("FAIL off_last_fd got=%b exp=0", fd); end
        checks++; if (c !== 24'hFFFFFF) begin failures++; $display("FAIL off_last_pix got=%h exp=ffffff", c); end
    endtask

    task automatic test_window();
        logic rd, fd; logic [15:0] a; logic [23:0] c;
        rom_const_en = 1'b0; mode = 2'd0; invert = 1'b0;
        win_x = 10'd700; win_y = 10'd200;
        frame_start();
        probe(500, 200, rd, a, fd, c);
        checks++; if (rd !== 1'b1 || a !== 16'd0) begin failures++; $display("FAIL win_reject_first got=rden%b/addr%0d exp=rden1/addr0", rd, a); end
        checks++; if (c !== 24'h000000) begin failures++; $display("FAIL win_reject_pix got=%h exp=000000", c); end
        probe(700, 200, rd, a, fd, c);
        checks++; if (rd !== 1'b0 || c !== 24'hFFFFFF) begin failures++; $display("FAIL win_reject_700 got=rden%b/%h exp=rden0/ffffff", rd, c); end
        win_x = 10'd640; win_y = 10'd320;
        frame_start();
        probe(639, 320, rd, a, fd, c);
        checks++; if (rd !== 1'b0 || c !== 24'hFFFFFF) begin failures++; $display("FAIL win_left_bg got=rden%b/%h exp=rden0/ffffff", rd, c); end
        probe(640, 319, rd, a, fd, c);
        checks++; if (rd !== 1'b0 || c !== 24'hFFFFFF) begin failures++; $display("FAIL win_above_bg got=rden%b/%h exp=rden0/ffffff", rd, c); end
        probe(640, 320, rd, a, fd, c);
        checks++; if (rd !== 1'b1 || a !== 16'd0) begin failures++; $display("FAIL win_new_first got=rden%b/addr%0d exp=rden1/addr0", rd, a); end
        scan_window(640, 320);
        probe(799, 479, rd, a, fd, c);
        checks++; if (a !== 16'd25599 || fd !== 1'b1) begin failures++; $display("FAIL win_new_last got=addr%0d/fd%b exp=addr25599/fd1", a, fd); end
        checks++; if (c !== 24'h0063FF) begin failures++; $display("FAIL win_new_last_pix got=%h exp=0063ff", c); end
    endtask

    task automatic test_midline_reset();
        logic rd, fd; logic [15:0] a; logic [23:0] c;
        @(negedge clk);
        pix_x = 10'd650; pix_y = 10'd330;
        @(posedge clk); #1;
        checks++; if (rom_rden !== 1'b1) begin failures++; $display("FAIL mlr_pre_rden got=%b exp=1", rom_rden); end
        rst = 1'b1;
        #1;
        checks++; if (rom_rden !== 1'b0 || rom_addr !== 16'd0 || frame_done !== 1'b0) begin failures++; $display("FAIL mlr_rom got=rden%b/addr%0d/fd%b exp=0/0/0", rom_rden, rom_addr, frame_done); end
        checks++; if (color_data_out !== 24'hFFFFFF) begin failures++; $display("FAIL mlr_color got=%h exp=ffffff", color_data_out); end
        @(negedge clk);
        rst = 1'b0;
        // Boundary pixel sitting inside a window at (0,0) uses the fresh latch
        rom_const_en = 1'b1; rom_const = 24'hFF0000;
        win_x = 10'd0; win_y = 10'd0; mode = 2'd1;
        probe(0, 0, rd, a, fd, c);
        checks++; if (rd !== 1'b1 || a !== 16'd0) begin failures++; $display("FAIL fb_inwin_rom got=rden%b/addr%0d exp=rden1/addr0", rd, a); end
        checks++; if (c !== 24'h4C4C4C) begin failures++; $display("FAIL fb_inwin_pix got=%h exp=4c4c4c", c); end
    endtask

    initial begin
        test_reset();
        test_colour();
        test_grey();
        test_binary();
        test_mode_change();
        test_window();
        test_midline_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
